// File: rtl/ita_package.sv
// ---------------------------------------------------------------------------
// ita_package : shared activation types, GELU constant widths, config struct
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ita_package;

   localparam int GELU_CONSTANTS_WIDTH = 8;
   localparam int EMS                  = 8;

   typedef enum logic [1:0] {
      IDENTITY = 2'd0,
      RELU     = 2'd1,
      GELU     = 2'd2
   } activation_e;

   typedef struct packed {
      activation_e                            mode;
      logic signed [GELU_CONSTANTS_WIDTH-1:0] one;
      logic signed [GELU_CONSTANTS_WIDTH-1:0] b;
      logic signed [GELU_CONSTANTS_WIDTH-1:0] c;
      logic        [EMS-1:0]                  eps_mult;
      logic        [EMS-1:0]                  right_shift;
   } activation_cfg_t;

endpackage

`default_nettype wire

// File: rtl/activation_lane.sv
// ---------------------------------------------------------------------------
// activation_lane : one lane of the 3-stage activation + requant datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module activation_lane #(
   parameter int WI  = 8,
   parameter int GCW = ita_package::GELU_CONSTANTS_WIDTH,
   parameter int EMS = ita_package::EMS
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  ita_package::activation_e mode_i,
   input  logic signed [GCW-1:0]   one_i,
   input  logic signed [GCW-1:0]   b_i,
   input  logic signed [GCW-1:0]   c_i,
   input  logic        [EMS-1:0]   eps_mult_i,
   input  logic        [EMS-1:0]   right_shift_i,
   input  logic signed [WI-1:0]    add_i,
   input  logic signed [WI-1:0]    q_i,
   output logic signed [WI-1:0]    res_o,
   output logic                    sat_o
);
   import ita_package::*;

   localparam int ACC_W  = WI + 2*GCW + 4;
   localparam int PROD_W = ACC_W + EMS + 2;
   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (WI-1)) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [WI-1:0]     q1_q, q2_q, res_q;
   logic signed [ACC_W-1:0]  t1_q, e2_q;
   logic                     sat_q;

   logic signed [ACC_W-1:0]  q_ext, q_abs, neg_b, t_d;
   logic signed [ACC_W-1:0]  sq_c, erf, e_d, g;
   logic signed [PROD_W-1:0] prod, rnd, shr, sum;
   logic signed [WI-1:0]     res_d;
   logic                     sat_d;

   // S1: clip |q| to -b, then shift by b
   always_comb begin
      q_ext = ACC_W'(q_i);
      q_abs = q_ext[ACC_W-1] ? -q_ext : q_ext;
      neg_b = -ACC_W'(b_i);
      t_d   = ((q_abs < neg_b) ? q_abs : neg_b) + ACC_W'(b_i);
   end

   // S2: erf polynomial with sign(0) = 0, then add one
   always_comb begin
      sq_c = t1_q * t1_q + ACC_W'(c_i);
      if (q1_q == '0)
         erf = '0;
      else if (q1_q[WI-1])
         erf = -sq_c;
      else
         erf = sq_c;
      e_d = erf + ACC_W'(one_i);
   end

   // S3: activation, rounding requant, saturation
   always_comb begin
      case (mode_i)
         GELU:    g = ACC_W'(q2_q) * e2_q;
         RELU:    g = q2_q[WI-1] ? '0 : ACC_W'(q2_q);
         default: g = ACC_W'(q2_q);
      endcase
      prod  = PROD_W'(g) * PROD_W'($signed({1'b0, eps_mult_i}));
      rnd   = (right_shift_i != '0) ? (PROD_W'(1) <<< (right_shift_i - EMS'(1))) : '0;
      shr   = (prod + rnd) >>> right_shift_i;
      sum   = shr + PROD_W'(add_i);
      res_d = sum[WI-1:0];
      sat_d = 1'b0;
      if (mode_i == IDENTITY) begin
         res_d = q2_q;
      end else if (sum > SAT_MAX) begin
         res_d = SAT_MAX[WI-1:0];
         sat_d = 1'b1;
      end else if (sum < SAT_MIN) begin
         res_d = SAT_MIN[WI-1:0];
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q1_q  <= '0;
         t1_q  <= '0;
         q2_q  <= '0;
         e2_q  <= '0;
         res_q <= '0;
         sat_q <= 1'b0;
      end else if (en_i) begin
         q1_q  <= q_i;
         t1_q  <= t_d;
         q2_q  <= q1_q;
         e2_q  <= e_d;
         res_q <= res_d;
         sat_q <= sat_d;
      end
   end

   assign res_o = res_q;
   assign sat_o = sat_q;

endmodule

`default_nettype wire

// File: rtl/activation_stream.sv
// ---------------------------------------------------------------------------
// activation_stream : streaming IDENTITY/RELU/i-GELU + requant, 3-stage pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module activation_stream #(
   parameter int N_LANES = 16,
   parameter int WI      = 8,
   parameter int GCW     = ita_package::GELU_CONSTANTS_WIDTH,
   parameter int EMS     = ita_package::EMS
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cfg_valid_i,
   output logic                      cfg_ready_o,
   input  ita_package::activation_e  cfg_mode_i,
   input  logic signed [GCW-1:0]     cfg_one_i,
   input  logic signed [GCW-1:0]     cfg_b_i,
   input  logic signed [GCW-1:0]     cfg_c_i,
   input  logic        [EMS-1:0]     cfg_eps_mult_i,
   input  logic        [EMS-1:0]     cfg_right_shift_i,
   input  logic signed [WI-1:0]      cfg_add_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [N_LANES*WI-1:0]     in_data_i,
   input  logic                      in_last_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [N_LANES*WI-1:0]     out_data_o,
   output logic                      out_last_o,
   output logic                      busy_o,
   output logic [15:0]               sat_count_o
);
   import ita_package::*;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam int         CW       = $clog2(N_LANES + 1);

   logic [1:0]            state_q, state_d;
   activation_cfg_t       cfg_q;
   logic signed [WI-1:0]  add_q;
   logic                  v1_q, v2_q, out_valid_q;
   logic                  l1_q, l2_q, out_last_q;
   logic [15:0]           sat_cnt_q;

   logic                  adv, cfg_fire, in_fire, out_fire;
   logic [N_LANES-1:0]    sat_vec;
   logic [N_LANES*WI-1:0] res_vec;
   logic [CW-1:0]         sat_n;
   logic [16:0]           cnt_sum;

   assign adv      = !out_valid_q || out_ready_i;
   assign cfg_fire = cfg_valid_i && cfg_ready_o;
   assign in_fire  = in_valid_i && in_ready_o;
   assign out_fire = out_valid_q && out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cfg_fire)               state_d = ST_RUN;
         ST_RUN:   if (in_fire && in_last_i)   state_d = ST_DRAIN;
         ST_DRAIN: if (out_fire && out_last_q) state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o = (state_q == ST_IDLE);
      busy_o      = (state_q != ST_IDLE);
      in_ready_o  = (state_q == ST_RUN) && adv;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q <= '0;
         add_q <= '0;
      end else if (cfg_fire) begin
         cfg_q.mode        <= cfg_mode_i;
         cfg_q.one         <= cfg_one_i;
         cfg_q.b           <= cfg_b_i;
         cfg_q.c           <= cfg_c_i;
         cfg_q.eps_mult    <= cfg_eps_mult_i;
         cfg_q.right_shift <= cfg_right_shift_i;
         add_q             <= cfg_add_i;
      end
   end

   // Valid/last travel alongside the lane data; all stages share one enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         l1_q        <= 1'b0;
         l2_q        <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (adv) begin
         v1_q        <= in_fire;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         l1_q        <= in_fire && in_last_i;
         l2_q        <= l1_q;
         out_last_q  <= l2_q;
      end
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lanes
      activation_lane #(
         .WI  (WI),
         .GCW (GCW),
         .EMS (EMS)
      ) u_lane (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .en_i          (adv),
         .mode_i        (cfg_q.mode),
         .one_i         (cfg_q.one),
         .b_i           (cfg_q.b),
         .c_i           (cfg_q.c),
         .eps_mult_i    (cfg_q.eps_mult),
         .right_shift_i (cfg_q.right_shift),
         .add_i         (add_q),
         .q_i           (in_data_i[i*WI +: WI]),
         .res_o         (res_vec[i*WI +: WI]),
         .sat_o         (sat_vec[i])
      );
   end

   always_comb begin
      sat_n = '0;
      for (int i = 0; i < N_LANES; i++)
         sat_n = sat_n + CW'(sat_vec[i]);
      cnt_sum = {1'b0, sat_cnt_q} + 17'(sat_n);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         sat_cnt_q <= '0;
      else if (cfg_fire)
         sat_cnt_q <= '0;
      else if (out_fire)
         sat_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_data_o  = res_vec;
   assign sat_count_o = sat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_activation_stream.sv
// ---------------------------------------------------------------------------
// tb_activation_stream : randomized self-checking bench with arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_activation_stream;
   import ita_package::*;

   localparam int NL = 16;
   localparam int W  = 8;
   localparam int CG = 8;
   localparam int CE = 8;
   localparam int DW = NL*W;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 cfg_valid_i, cfg_ready_o;
   activation_e          cfg_mode_i;
   logic signed [CG-1:0] cfg_one_i, cfg_b_i, cfg_c_i;
   logic        [CE-1:0] cfg_eps_mult_i, cfg_right_shift_i;
   logic signed [W-1:0]  cfg_add_i;
   logic                 in_valid_i, in_ready_o, in_last_i;
   logic [DW-1:0]        in_data_i;
   logic                 out_valid_o, out_ready_i, out_last_o;
   logic [DW-1:0]        out_data_o;
   logic                 busy_o;
   logic [15:0]          sat_count_o;

   activation_stream #(.N_LANES(NL), .WI(W), .GCW(CG), .EMS(CE)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_mode_i(cfg_mode_i),
      .cfg_one_i(cfg_one_i), .cfg_b_i(cfg_b_i), .cfg_c_i(cfg_c_i),
      .cfg_eps_mult_i(cfg_eps_mult_i), .cfg_right_shift_i(cfg_right_shift_i), .cfg_add_i(cfg_add_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_last_o(out_last_o), .busy_o(busy_o), .sat_count_o(sat_count_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc = cyc + 1;

   int errors = 0;
   int checks = 0;

   // Reference configuration, held only by the bench
   int     m_mode;
   longint m_one, m_b, m_c, m_eps, m_sh, m_add;
   int     m_sat;
   logic [DW-1:0] last_out;
   int     last_lat;
   int     last_cycles;

   function automatic int lane_ref(input longint q, output bit sat);
      longint a, t, s, g, r;
      sat = 1'b0;
      if (m_mode == 0) return int'(q);
      if (m_mode == 1) begin
         g = (q > 0) ? q : 64'sd0;
      end else begin
         a = (q < 0) ? -q : q;
         t = ((a < -m_b) ? a : -m_b) + m_b;
         s = (q > 0) ? 64'sd1 : ((q < 0) ? -64'sd1 : 64'sd0);
         g = q * (s * (t * t + m_c) + m_one);
      end
      r = g * m_eps + ((m_sh > 0) ? (64'sd1 <<< (m_sh - 1)) : 64'sd0);
      r = r >>> m_sh;
      r = r + m_add;
      if (r > 127) begin r = 127; sat = 1'b1; end
      else if (r < -128) begin r = -128; sat = 1'b1; end
      return int'(r);
   endfunction

   function automatic void beat_ref(input logic [DW-1:0] d, output logic [DW-1:0] o, output int ns);
      bit s;
      int v;
      ns = 0;
      o  = '0;
      for (int i = 0; i < NL; i++) begin
         v = lane_ref(longint'($signed(d[i*W +: W])), s);
         o[i*W +: W] = v[W-1:0];
         ns += int'(s);
      end
   endfunction

   function automatic logic [DW-1:0] alt(input int a, input int b);
      logic [DW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*W +: W] = (i % 2 == 0) ? W'(a) : W'(b);
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*W +: W] = W'($urandom);
      return r;
   endfunction

   function automatic int rs8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic do_cfg(input int mode, input int one, input int b, input int c,
                         input int eps, input int sh, input int add);
      int k;
      @(negedge clk_i);
      cfg_mode_i        = activation_e'(2'(mode));
      cfg_one_i         = CG'(one);
      cfg_b_i           = CG'(b);
      cfg_c_i           = CG'(c);
      cfg_eps_mult_i    = CE'(eps);
      cfg_right_shift_i = CE'(sh);
      cfg_add_i         = W'(add);
      cfg_valid_i       = 1'b1;
      m_mode = mode; m_one = one; m_b = b; m_c = c; m_eps = eps; m_sh = sh; m_add = add;
      k = 0;
      #1;
      while (!cfg_ready_o && k < 50) begin
         @(negedge clk_i); #1; k++;
      end
      checks++;
      if (cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL cfg_accept: cfg_ready_o=%b required 1", cfg_ready_o);
      end
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      m_sat = 0;
   endtask

   task automatic do_rand_cfg(input int mode);
      do_cfg(mode, rs8(), rs8(), rs8(), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 12)), rs8());
   endtask

   // Streams n beats; stall_mode 0: always ready, 1: ready low on cycles 4-8, 2: random
   task automatic run_packet(input int n, input int stall_mode, input bit fixed,
                             input logic [DW-1:0] fixed_data, input bit toggle);
      logic [DW-1:0] exp_q[$];
      bit            exp_l_q[$];
      int            ns_q[$];
      logic [DW-1:0] cur, e, prev_d;
      bit            el, prev_stall, prev_last, ofire, ifire;
      int            ns, sent, got, k, t_acc, sat_exp;
      sent = 0; got = 0; k = 0; t_acc = -1; prev_stall = 1'b0; prev_last = 1'b0; prev_d = '0;
      last_lat = -1;
      cur = fixed ? fixed_data : rand_beat();
      while (got < n && k < 2000) begin
         @(negedge clk_i);
         k++;
         if (prev_stall) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== prev_d || out_last_o !== prev_last) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                        out_valid_o, out_data_o, out_last_o, prev_d, prev_last);
            end
         end
         case (stall_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = !(k >= 4 && k <= 8);
            default: out_ready_i = ($urandom_range(0, 3) != 0);
         endcase
         if (sent < n) begin
            in_valid_i = 1'b1;
            in_data_i  = cur;
            in_last_i  = (sent == n - 1);
         end else begin
            in_valid_i = 1'b0;
            in_last_i  = 1'b0;
         end
         if (toggle && !cfg_ready_o) begin
            cfg_valid_i       = 1'($urandom);
            cfg_mode_i        = activation_e'(2'($urandom_range(0, 2)));
            cfg_one_i         = CG'($urandom);
            cfg_b_i           = CG'($urandom);
            cfg_c_i           = CG'($urandom);
            cfg_eps_mult_i    = CE'($urandom);
            cfg_right_shift_i = CE'($urandom);
            cfg_add_i         = W'($urandom);
         end else begin
            cfg_valid_i = 1'b0;
         end
         #1;
         ofire = out_valid_o && out_ready_i;
         ifire = in_valid_i && in_ready_o;
         if (out_valid_o && last_lat < 0 && t_acc >= 0) last_lat = cyc - t_acc;
         if (ofire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: data=%h arrived with none outstanding (required none)", out_data_o);
            end else begin
               e  = exp_q.pop_front();
               el = exp_l_q.pop_front();
               m_sat += ns_q.pop_front();
               if (out_data_o !== e || out_last_o !== el) begin
                  errors++;
                  $display("FAIL out_beat%0d: data=%h last=%b required data=%h last=%b",
                           got, out_data_o, out_last_o, e, el);
               end
            end
            last_out = out_data_o;
            got++;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_d     = out_data_o;
         prev_last  = out_last_o;
         if (ifire) begin
            beat_ref(cur, e, ns);
            exp_q.push_back(e);
            exp_l_q.push_back(sent == n - 1);
            ns_q.push_back(ns);
            if (t_acc < 0) t_acc = cyc;
            sent++;
            cur = fixed ? fixed_data : rand_beat();
         end
      end
      last_cycles = k;
      in_valid_i  = 1'b0;
      in_last_i   = 1'b0;
      cfg_valid_i = 1'b0;
      out_ready_i = 1'b1;
      checks++;
      if (got < n) begin
         errors++;
         $display("FAIL packet_timeout: beats=%0d required %0d", got, n);
      end
      @(negedge clk_i);
      sat_exp = (m_sat > 65535) ? 65535 : m_sat;
      checks++;
      if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL end_idle: busy=%b cfg_ready=%b out_valid=%b required 0 1 0",
                  busy_o, cfg_ready_o, out_valid_o);
      end
      checks++;
      if (sat_count_o !== 16'(sat_exp)) begin
         errors++;
         $display("FAIL sat_count: got %0d required %0d", sat_count_o, sat_exp);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({out_valid_o, out_last_o, busy_o, cfg_ready_o, in_ready_o} !== 5'b00010) begin
         errors++;
         $display("FAIL reset_ctrl: valid,last,busy,cfg_ready,in_ready=%b required 00010",
                  {out_valid_o, out_last_o, busy_o, cfg_ready_o, in_ready_o});
      end
      checks++;
      if (out_data_o !== '0 || sat_count_o !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: data=%h sat=%0d required 0 0", out_data_o, sat_count_o);
      end
   endtask

   task automatic test_gelu;
      do_cfg(2, 16, -4, -16, 1, 0, 0);
      run_packet(1, 0, 1'b1, alt(2, 2), 1'b0);
      checks++;
      if (last_out !== alt(8, 8)) begin
         errors++;
         $display("FAIL gelu_q2: got %h required %h", last_out, alt(8, 8));
      end
      checks++;
      if (last_lat != 3) begin
         errors++;
         $display("FAIL latency: got %0d required 3", last_lat);
      end
      do_cfg(2, 16, -4, -16, 1, 0, 5);
      run_packet(1, 0, 1'b1, alt(0, 0), 1'b0);
      checks++;
      if (last_out !== alt(5, 5)) begin
         errors++;
         $display("FAIL gelu_q0_add: got %h required %h", last_out, alt(5, 5));
      end
      do_rand_cfg(2);
      run_packet(6, 2, 1'b0, '0, 1'b0);
   endtask

   task automatic test_relu;
      do_cfg(1, 0, 0, 0, 3, 1, 0);
      run_packet(1, 0, 1'b1, alt(8, -8), 1'b0);
      checks++;
      if (last_out !== alt(12, 0)) begin
         errors++;
         $display("FAIL relu_8: got %h required %h", last_out, alt(12, 0));
      end
      do_rand_cfg(1);
      run_packet(5, 0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_saturation;
      do_cfg(1, 0, 0, 0, 4, 0, 0);
      run_packet(1, 0, 1'b1, alt(127, 127), 1'b0);
      checks++;
      if (last_out !== alt(127, 127) || sat_count_o !== 16'd16) begin
         errors++;
         $display("FAIL relu_sat: data=%h sat=%0d required %h 16", last_out, sat_count_o, alt(127, 127));
      end
      do_cfg(1, 0, 0, 0, 1, 0, 0);
      checks++;
      if (sat_count_o !== 16'd0) begin
         errors++;
         $display("FAIL sat_clear: got %0d required 0", sat_count_o);
      end
      run_packet(2, 0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_stall;
      do_rand_cfg(2);
      run_packet(10, 1, 1'b0, '0, 1'b0);
   endtask

   task automatic test_identity;
      do_cfg(0, rs8(), rs8(), rs8(), 200, 3, 100);
      run_packet(4, 0, 1'b1, alt(-128, -128), 1'b1);
      checks++;
      if (last_out !== alt(-128, -128) || sat_count_o !== 16'd0) begin
         errors++;
         $display("FAIL identity: data=%h sat=%0d required %h 0", last_out, sat_count_o, alt(-128, -128));
      end
      do_rand_cfg(2);
      run_packet(8, 2, 1'b0, '0, 1'b1);
   endtask

   task automatic test_back_to_back;
      do_rand_cfg(int'($urandom_range(0, 2)));
      run_packet(8, 0, 1'b0, '0, 1'b0);
      checks++;
      if (last_cycles != 11) begin
         errors++;
         $display("FAIL throughput: 8 beats took %0d cycles required 11", last_cycles);
      end
   endtask

   task automatic test_reset_midflight;
      int acc, k;
      acc = 0; k = 0;
      do_cfg(1, 0, 0, 0, 1, 0, 0);
      while (acc < 3 && k < 20) begin
         @(negedge clk_i);
         k++;
         out_ready_i = 1'b0;
         in_valid_i  = 1'b1;
         in_data_i   = alt(5, 5);
         in_last_i   = 1'b0;
         #1;
         if (in_ready_o) acc++;
      end
      @(negedge clk_i);
      checks++;
      if (acc != 3 || out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL inflight_fill: accepted=%0d valid=%b required 3 1", acc, out_valid_o);
      end
      in_valid_i = 1'b0;
      rst_i      = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || cfg_ready_o !== 1'b1 ||
          out_data_o !== '0 || out_last_o !== 1'b0 || sat_count_o !== 16'd0) begin
         errors++;
         $display("FAIL midflight_reset: valid=%b busy=%b cfg_ready=%b data=%h last=%b sat=%0d required 0 0 1 0 0 0",
                  out_valid_o, busy_o, cfg_ready_o, out_data_o, out_last_o, sat_count_o);
      end
      out_ready_i = 1'b1;
      do_rand_cfg(2);
      run_packet(5, 2, 1'b0, '0, 1'b0);
   endtask

   task automatic test_random;
      for (int p = 0; p < 6; p++) begin
         do_rand_cfg(int'($urandom_range(0, 2)));
         run_packet(int'($urandom_range(1, 8)), 2, 1'b0, '0, 1'b0);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      cfg_valid_i = 1'b0; cfg_mode_i = IDENTITY;
      cfg_one_i = '0; cfg_b_i = '0; cfg_c_i = '0;
      cfg_eps_mult_i = '0; cfg_right_shift_i = '0; cfg_add_i = '0;
      in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0; out_ready_i = 1'b1;
      m_sat = 0; last_out = '0; last_lat = -1; last_cycles = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      test_reset;
      test_gelu;
      test_relu;
      test_saturation;
      test_stall;
      test_identity;
      test_back_to_back;
      test_reset_midflight;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
